mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter that shares one single-ported, Avalon-style memory between the processor's instruction-fetch port and its data (load/store) port. It sits between `processor` and the memory.

- Each requester sees a waitrequest handshake.
- The arbiter holds one outstanding memory transaction at a time.
- Data accesses have priority, with a starvation guard so fetch always makes progress.

## Interface
Parameters:
- WORD_SIZE, 16, width of address and data words
- STARVE_LIMIT, 4, consecutive contested data grants before instruction fetch is forced through (1..15)

Ports:
- Clock  in  1  clock, all state on rising edge
- Reset  in  1  reset, synchronous, active-high
- DataAddr  in  WORD_SIZE  data-port address
- DataOut  in  WORD_SIZE  store data from processor
- ReadData  in  1  data-port read request
- WriteData  in  1  data-port write request
- DataIn  out  WORD_SIZE  load data to processor, registered
- DataWaitreq  out  1  data request not yet complete
- InstrAddr  in  WORD_SIZE  fetch address
- InstrRead  in  1  fetch request
- InstrIn  out  WORD_SIZE  fetched word, registered
- InstrWaitreq  out  1  fetch request not yet complete
- MemAddr  out  WORD_SIZE  memory address
- MemWriteData  out  WORD_SIZE  memory write data
- MemRead  out  1  memory read command
- MemWrite  out  1  memory write command
- MemReadData  in  WORD_SIZE  memory read data
- MemWaitreq  in  1  memory not accepting command this cycle
- MemReadValid  in  1  MemReadData valid

## Operation
States: IDLE, ISSUE, WAIT_RD, DONE. Owner register: DATA or INSTR.

- **IDLE**
  - No request: stay in IDLE.
  - Otherwise grant per priority and go to ISSUE.
  - At grant, register address, write data and op. The memory outputs are driven only from these registers, so later requester changes are ignored.
- **Priority**
  - Data wins a contest unless starve_cnt == STARVE_LIMIT; then instruction wins.
  - ReadData and WriteData both high is illegal; treat it as a write.
- **ISSUE**
  - Drive MemRead or MemWrite with the registered address and data.
  - Hold while MemWaitreq = 1.
  - On acceptance: write goes to DONE; read goes to WAIT_RD.
- **WAIT_RD**
  - Deassert the command.
  - On MemReadValid, capture MemReadData into DataIn or InstrIn, according to owner, and go to DONE.
  - MemReadValid is ignored in every other state.
- **DONE**
  - The owner's waitreq is low for exactly this cycle.
  - Always return to IDLE next cycle.
- **Waitreq outputs (combinational)**
  - DataWaitreq = (ReadData|WriteData) & !(DONE & owner==DATA).
  - InstrWaitreq = InstrRead & !(DONE & owner==INSTR).
- **starve_cnt** (4-bit, updated only on IDLE grants)
  - +1, saturating, when data is granted while InstrRead = 1.
  - Cleared when instruction is granted, or when data is granted with InstrRead = 0.
- **Requester rules**
  - A requester holds its request and address stable until it sees its waitreq low.
  - If it drops the request mid-transaction, the transaction still completes.
  - Read data is still written to DataIn/InstrIn; no re-issue occurs.
- **DataIn/InstrIn** hold their last captured value until the next read by the same owner.

## Timing
- **Reset values**
  - State IDLE, owner DATA, starve_cnt 0.
  - MemRead = MemWrite = 0; MemAddr, MemWriteData, DataIn, InstrIn = 0.
  - Waitreqs follow their formulas, i.e. equal the raw requests.
- **Reset mid-transaction** abandons the transaction in any state. A MemReadValid arriving after reset is ignored.
- **Latency** is measured from the request seen in IDLE at cycle 0, with memory ready:
  - Write: ISSUE at cycle 1, DONE at cycle 2.
  - Read: ISSUE at 1, WAIT_RD at 2, MemReadValid at 2, DONE at 3.
  - Each MemWaitreq cycle adds 1; each extra cycle of read latency adds 1.
- **Back-to-back**: the next grant occurs in IDLE at DONE+1. Peak throughput is one write per 3 cycles, one read per 4 cycles.
- **Simultaneous requests** are resolved only in IDLE. A request arriving mid-transaction waits, with waitreq high.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD, ARB_DONE}
  - typedef enum arb_owner_t {OWN_DATA, OWN_INSTR}
- No sub-module. The FSM, starvation counter and capture registers form a single module.

## Test plan
- **Lone fetch**: InstrRead = 1, InstrAddr = 0x0010, memory returns 0xA5A5 one cycle after accept → InstrWaitreq low at cycle 3 only; InstrIn = 0xA5A5; MemRead high at cycle 1 only.
- **Store with memory stall**: WriteData = 1, DataAddr = 0x0200, DataOut = 0x1234, MemWaitreq high for 2 cycles → MemWrite high cycles 1–3, DataWaitreq low at cycle 4; MemAddr/MemWriteData stable at 0x0200/0x1234.
- **Contest**: ReadData and InstrRead both held high → data granted first; instruction granted in the IDLE following data's DONE, provided data drops its request.
- **Starvation**: ReadData and InstrRead held continuously, STARVE_LIMIT = 4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I.
- **Reset mid-read**: Reset in WAIT_RD, then MemReadValid = 1 with 0xFFFF the next cycle → state IDLE; DataIn stays 0; no waitreq-low pulse.
- **Dropped request**: InstrRead falls during ISSUE → MemRead still completes; InstrIn updated; next IDLE issues no fetch.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RD,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_DATA,
        OWN_INSTR
    } arb_owner_t;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Avalon-style single-port memory bus between the arbiter (master) and memory (slave).
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
) ();

    logic [WORD_SIZE-1:0] MemAddr;
    logic [WORD_SIZE-1:0] MemWriteData;
    logic                 MemRead;
    logic                 MemWrite;
    logic [WORD_SIZE-1:0] MemReadData;
    logic                 MemWaitreq;
    logic                 MemReadValid;

    modport master (
        output MemAddr, MemWriteData, MemRead, MemWrite,
        input  MemReadData, MemWaitreq, MemReadValid
    );

    modport slave (
        input  MemAddr, MemWriteData, MemRead, MemWrite,
        output MemReadData, MemWaitreq, MemReadValid
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports;
// data has priority, with a starvation guard that forces fetch through.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    input  logic                 InstrRead,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrWaitreq,
    mem_port_arbiter_if.master   mem
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    arb_state_t           state_q, state_d;
    arb_owner_t           owner_q, owner_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 write_q;
    logic                 data_req;
    logic                 instr_wins;
    logic                 grant;
    logic                 capture;

    assign data_req   = ReadData | WriteData;
    // Fetch wins when data is idle, or when data has won STARVE_LIMIT contests in a row.
    assign instr_wins = InstrRead && (!data_req || (starve_q == STARVE_LIM));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_DATA;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        grant        = 1'b0;
        capture      = 1'b0;
        mem.MemRead  = 1'b0;
        mem.MemWrite = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (data_req || InstrRead) begin
                    grant   = 1'b1;
                    state_d = ARB_ISSUE;
                    if (instr_wins) begin
                        owner_d  = OWN_INSTR;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_DATA;
                        if (!InstrRead)
                            starve_d = '0;
                        else if (starve_q != STARVE_MAX)
                            starve_d = starve_q + 1'b1;
                    end
                end
            end
            ARB_ISSUE: begin
                mem.MemRead  = !write_q;
                mem.MemWrite = write_q;
                if (!mem.MemWaitreq)
                    state_d = write_q ? ARB_DONE : ARB_WAIT_RD;
            end
            ARB_WAIT_RD: begin
                if (mem.MemReadValid) begin
                    capture = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Command is latched at grant so requester changes mid-transaction have no effect.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            DataIn  <= '0;
            InstrIn <= '0;
        end else begin
            if (grant) begin
                addr_q  <= instr_wins ? InstrAddr : DataAddr;
                write_q <= !instr_wins && WriteData;
                if (!instr_wins && WriteData)
                    wdata_q <= DataOut;
            end
            if (capture) begin
                if (owner_q == OWN_INSTR)
                    InstrIn <= mem.MemReadData;
                else
                    DataIn <= mem.MemReadData;
            end
        end
    end

    assign mem.MemAddr      = addr_q;
    assign mem.MemWriteData = wdata_q;

    assign DataWaitreq  = data_req  && !((state_q == ARB_DONE) && (owner_q == OWN_DATA));
    assign InstrWaitreq = InstrRead && !((state_q == ARB_DONE) && (owner_q == OWN_INSTR));

endmodule
